axis_route_scheduler: RTL and testbench

Sequencing controller for the two-way AXI-stream demultiplexer. Sits between an upstream stream source and the selector input, and drives the selector's `sel` line according to a programmed schedule: `len0` beats to output 0, then `len1` beats to output 1, repeated `rounds` times. `sel` changes only between beats, so no beat is split or misrouted. The stream is gated closed whenever no schedule is running.

---
 rtl/ising_pkg.sv | 12 +
 rtl/axis_route_scheduler.sv | 155 +++++++++++++++
 tb/tb_axis_route_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ising_pkg.sv
// Shared types for the stream routing scheduler.
// Holds the scheduler FSM state encoding.
package ising_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2,
    DONE   = 2'd3
  } route_state_t;

endpackage

// File: rtl/axis_route_scheduler.sv
// Gates an AXI stream and steers the demux select line
// through len0/len1 beat phases for a number of rounds.
module axis_route_scheduler
  import ising_pkg::*;
#(
  parameter int width     = 16,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [width-1:0]     s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [width-1:0]     m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 sel,
  input  logic                 start,
  input  logic                 abort,
  input  logic [cnt_width-1:0] len0,
  input  logic [cnt_width-1:0] len1,
  input  logic [cnt_width-1:0] rounds,
  output logic                 busy,
  output logic                 done
);

  localparam logic [cnt_width-1:0] one = cnt_width'(1);

  route_state_t         state;
  route_state_t         state_nxt;
  logic [cnt_width-1:0] beat_cnt;
  logic [cnt_width-1:0] beat_nxt;
  logic [cnt_width-1:0] round_cnt;
  logic [cnt_width-1:0] round_nxt;
  logic [cnt_width-1:0] l0_q;
  logic [cnt_width-1:0] l1_q;
  logic [cnt_width-1:0] rn_q;
  logic                 active;
  logic                 beat;
  logic                 last0;
  logic                 last1;
  logic                 last_round;
  logic                 end_round;
  logic                 load;

  assign active = (state == ROUTE0) || (state == ROUTE1);

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = s_axis_tvalid & active;
  assign s_axis_tready = m_axis_tready & active;

  assign beat = m_axis_tvalid & m_axis_tready;

  assign last0      = beat_cnt == (l0_q - one);
  assign last1      = beat_cnt == (l1_q - one);
  assign last_round = round_cnt == (rn_q - one);

  assign load = (state == IDLE) && start && !abort;

  assign busy = active;
  assign done = state == DONE;

  // Next state and counter values; abort overrides everything.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    round_nxt = round_cnt;
    end_round = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        if (start) begin
          beat_nxt  = '0;
          round_nxt = '0;
          if (rounds == '0 || (len0 == '0 && len1 == '0))
            state_nxt = DONE;
          else if (len0 == '0)
            state_nxt = ROUTE1;
          else
            state_nxt = ROUTE0;
        end
      end
      state == ROUTE0: begin
        if (beat) begin
          if (last0) begin
            beat_nxt = '0;
            if (l1_q != '0)
              state_nxt = ROUTE1;
            else
              end_round = 1'b1;
          end else begin
            beat_nxt = beat_cnt + one;
          end
        end
      end
      state == ROUTE1: begin
        if (beat) begin
          if (last1) begin
            beat_nxt  = '0;
            end_round = 1'b1;
          end else begin
            beat_nxt = beat_cnt + one;
          end
        end
      end
      state == DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (end_round) begin
      if (last_round) begin
        state_nxt = DONE;
      end else begin
        round_nxt = round_cnt + one;
        state_nxt = (l0_q == '0) ? ROUTE1 : ROUTE0;
      end
    end
    if (abort) begin
      state_nxt = IDLE;
      beat_nxt  = '0;
      round_nxt = '0;
    end
  end

  // State, counters and registered select.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      round_cnt <= '0;
      sel       <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_nxt;
      round_cnt <= round_nxt;
      sel       <= state_nxt == ROUTE1;
    end
  end

  // Schedule parameters captured on an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l0_q <= '0;
      l1_q <= '0;
      rn_q <= '0;
    end else if (load) begin
      l0_q <= len0;
      l1_q <= len1;
      rn_q <= rounds;
    end
  end

endmodule

// File: tb/tb_axis_route_scheduler.sv
// Bench for axis_route_scheduler: random stalls against a
// per-beat expected select list built from the schedule.
module tb_axis_route_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        sel;
  logic        start;
  logic        abort;
  logic [15:0] len0;
  logic [15:0] len1;
  logic [15:0] rounds;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_route_scheduler #(.width(16), .cnt_width(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .sel(sel),
    .start(start),
    .abort(abort),
    .len0(len0),
    .len1(len1),
    .rounds(rounds),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".sel"}, 32'(sel), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".tready"}, 32'(s_axis_tready), 0);
    chk({tag, ".tvalid"}, 32'(m_axis_tvalid), 0);
  endtask

  // ghost: loop cycle to pulse a stray start; abort_at/rst_at:
  // beat index at which abort or reset is driven (-1 = never).
  task automatic run(input int l0, input int l1, input int r,
                     input bit stall, input int ghost,
                     input int abort_at, input int rst_at);
    int  exp_sel[$];
    int  idx = 0;
    int  cyc = 0;
    bit  stop = 0;
    bit  bt;
    for (int k = 0; k < r; k++) begin
      for (int i = 0; i < l0; i++) exp_sel.push_back(0);
      for (int i = 0; i < l1; i++) exp_sel.push_back(1);
    end
    len0   = 16'(l0);
    len1   = 16'(l1);
    rounds = 16'(r);
    start  = 1'b1;
    @(posedge clk) #1;
    start  = 1'b0;
    len0   = 16'($urandom);
    len1   = 16'($urandom);
    rounds = 16'($urandom);
    while (idx < exp_sel.size() && !stop) begin
      s_axis_tvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axis_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_tdata  = 16'($urandom);
      start = (cyc == ghost);
      abort = (abort_at >= 0) && (idx == abort_at);
      rst_n = !((rst_at >= 0) && (idx == rst_at));
      @(negedge clk);
      bt = s_axis_tvalid & m_axis_tready;
      chk("busy", 32'(busy), 1);
      chk("done_mid", 32'(done), 0);
      chk("gate_ready", 32'(s_axis_tready), 32'(m_axis_tready));
      chk("gate_valid", 32'(m_axis_tvalid), 32'(s_axis_tvalid));
      if (bt) begin
        chk($sformatf("sel[%0d]", idx), 32'(sel), 32'(exp_sel[idx]));
        chk("data", 32'(m_axis_tdata), 32'(s_axis_tdata));
      end
      if (abort || !rst_n) stop = 1;
      else if (bt) idx++;
      cyc++;
      if (cyc > 2000) begin
        chk("timeout", 32'(idx), 32'(exp_sel.size()));
        stop = 1;
      end
      @(posedge clk) #1;
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    if (stop) begin
      idle_outputs("after_stop");
    end else begin
      chk("done_pulse", 32'(done), 1);
      chk("done_busy", 32'(busy), 0);
      chk("done_sel", 32'(sel), 0);
      chk("done_gate", 32'(s_axis_tready), 0);
      if (!stall)
        chk("no_bubbles", 32'(cyc), 32'(exp_sel.size()));
    end
    @(posedge clk) #1;
    @(negedge clk);
    idle_outputs("idle");
    @(posedge clk) #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    len0 = '0;
    len1 = '0;
    rounds = '0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk) #1;
    @(negedge clk);
    idle_outputs("idle0");
    @(posedge clk) #1;

    run(3, 2, 2, 0, -1, -1, -1);
    run(3, 2, 2, 1, -1, -1, -1);
    run(3, 2, 2, 1, -1, -1, -1);
    run(0, 4, 1, 0, -1, -1, -1);
    run(4, 0, 2, 1, -1, -1, -1);
    run(3, 2, 0, 0, -1, -1, -1);
    run(0, 0, 3, 0, -1, -1, -1);
    run(1, 1, 1, 0, -1, -1, -1);
    run(5, 2, 1, 0, -1, 2, -1);
    run(5, 2, 1, 0, -1, -1, -1);
    run(2, 3, 3, 1, 2, -1, -1);
    run(1, 5, 1, 0, -1, -1, 3);
    run(2, 2, 1, 0, -1, -1, -1);
    for (int t = 0; t < 6; t++)
      run($urandom_range(0, 4), $urandom_range(0, 4),
          $urandom_range(0, 3), 1, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
